// File: rtl/data_memory.sv
// data_memory: byte-addressable data RAM plus LED register, multi-cycle access with clk_stall.
module data_memory #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000,
  parameter logic [31:0] LED_ADDR    = 32'h2000,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic [7:0]  led,
  output logic        clk_stall
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, BUF, RD, WR} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, buf_q;
  logic [3:0]  mask_q, mask_d, be;
  logic        wr_q, wr_d, stall_q, stall_d, start, is_led, mem_we, sgn;
  logic [7:0]  led_q, led_d, byte_v;
  logic [15:0] half_v;
  logic [31:0] wrep, merged, load_val;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? ((memread | memwrite) ? BUF : IDLE) :
              state_q == BUF  ? (wr_q ? WR : RD) : IDLE;
  assign start  = state_q == IDLE && (memread | memwrite);
  assign is_led = addr_q == LED_ADDR;
  assign idx    = AW'((addr_q - BASE_ADDR) >> 2);
  assign sgn    = mask_q[3];
  assign byte_v = 8'(buf_q >> {addr_q[1:0], 3'b000});
  assign half_v = addr_q[1] ? buf_q[31:16] : buf_q[15:0];
  assign be     = mask_q[2] ? 4'hF : mask_q[1] ? (addr_q[1] ? 4'hC : 4'h3) : 4'b0001 << addr_q[1:0];
  assign wrep   = mask_q[2] ? wdata_q : mask_q[1] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  always_comb begin
    merged = buf_q;
    for (int i = 0; i < 4; i++) merged[8*i+:8] = be[i] ? wrep[8*i+:8] : buf_q[8*i+:8];
  end
  assign load_val = is_led    ? {24'b0, led_q} :
                    mask_q[2] ? buf_q :
                    mask_q[1] ? {{16{sgn & half_v[15]}}, half_v} :
                                {{24{sgn & byte_v[7]}}, byte_v};
  always_comb begin
    addr_d  = start ? addr : addr_q;
    wdata_d = start ? write_data : wdata_q;
    mask_d  = start ? sign_mask : mask_q;
    wr_d    = start ? memwrite : wr_q;
    stall_d = start ? 1'b1 : (state_q == RD || state_q == WR) ? 1'b0 : stall_q;
    rdata_d = state_q == RD ? load_val : rdata_q;
    led_d   = state_q == WR && is_led ? wdata_q[7:0] : led_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      wr_q    <= 1'b0;
      stall_q <= 1'b0;
      rdata_q <= '0;
      led_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      wr_q    <= wr_d;
      stall_q <= stall_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
    end
  assign mem_we = state_q == WR && !is_led && !reset;
  always_ff @(posedge clk) begin
    if (state_q == BUF) buf_q <= mem[idx];
    if (mem_we) mem[idx] <= merged;
  end
  assign read_data = rdata_q;
  assign led       = led_q;
  assign clk_stall = stall_q;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized and directed checks of data_memory against a byte-array reference.
module tb_data_memory;
  localparam logic [31:0] BASE = 32'h1000, LEDA = 32'h2000;
  localparam int DW = 1024;
  logic clk = 0, reset = 1, memwrite = 0, memread = 0;
  logic [31:0] addr = 0, write_data = 0, read_data;
  logic [3:0] sign_mask = 0;
  logic [7:0] led;
  logic clk_stall;
  int checks = 0, errors = 0;
  logic [7:0] mb [DW*4];
  logic [7:0] led_m = 0;
  logic [31:0] last_rd = 0;

  data_memory dut (
    .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
    .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
    .read_data(read_data), .led(led), .clk_stall(clk_stall)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [3:0] sm);
    return sm[2] ? 4 : sm[1] ? 2 : 1;
  endfunction

  function automatic int base_byte(input logic [31:0] a, input logic [3:0] sm);
    int w, n, off;
    w = int'(((a - BASE) >> 2) % DW);
    n = nbytes(sm);
    off = n == 4 ? 0 : n == 2 ? int'(a[1]) * 2 : int'(a[1:0]);
    return w * 4 + off;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [3:0] sm);
    logic [31:0] v;
    int n, b;
    if (a == LEDA) return {24'b0, led_m};
    n = nbytes(sm);
    b = base_byte(a, sm);
    v = 0;
    for (int k = 0; k < n; k++) v = v | (32'(mb[b+k]) << (8*k));
    if (sm[3] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sm);
    int n, b;
    if (a == LEDA) begin
      led_m = wd[7:0];
      return;
    end
    n = nbytes(sm);
    b = base_byte(a, sm);
    for (int k = 0; k < n; k++) mb[b+k] = 8'(wd >> (8*k));
  endtask

  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sm, output int edges);
    @(negedge clk);
    addr = a; write_data = wd; memwrite = wr; memread = rd; sign_mask = sm;
    @(posedge clk);
    edges = 1;
    #1;
    memwrite = 0; memread = 0;
    while (clk_stall && edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (wr) ref_store(a, wd, sm);
    else if (rd) begin
      last_rd = ref_load(a, sm);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_store(input string name, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sm);
    int e;
    access(1, 0, a, wd, sm, e);
    checks++;
    if (e !== 3) begin
      errors++;
      $display("FAIL %s latency: got %0d edges expected 3", name, e);
    end
  endtask

  task automatic do_load(input string name, input logic [31:0] a, input logic [3:0] sm);
    int e;
    access(0, 1, a, 0, sm, e);
    checks++;
    if (e !== 3) begin
      errors++;
      $display("FAIL %s latency: got %0d edges expected 3", name, e);
    end
    checks++;
    if (read_data !== last_rd) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, read_data, last_rd);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (clk_stall !== 1'b0 || read_data !== 32'h0 || led !== 8'h0) begin
      errors++;
      $display("FAIL reset: got stall=%b rd=%h led=%h expected 0/0/0", clk_stall, read_data, led);
    end
    reset = 0;
  endtask

  task automatic test_reset_mid_buf;
    do_store("pre_word", 32'h1010, 32'h1122_3344, 4'b0111);
    do_store("pre_led", LEDA, 32'h0000_005A, 4'b0111);
    chk("pre_led_val", {24'b0, led}, 32'h5A);
    @(negedge clk);
    addr = 32'h1010; write_data = 32'hAAAA_AAAA; memwrite = 1; sign_mask = 4'b0111;
    @(posedge clk);
    #1;
    memwrite = 0;
    reset = 1;
    #2;
    checks++;
    if (clk_stall !== 1'b0 || led !== 8'h0 || read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_buf: got stall=%b led=%h rd=%h expected 0/0/0", clk_stall, led, read_data);
    end
    led_m = 0;
    last_rd = 0;
    @(negedge clk);
    reset = 0;
    do_load("reset_word_kept", 32'h1010, 4'b0111);
  endtask

  task automatic test_directed;
    do_store("sw_dead", 32'h1000, 32'hDEAD_BEEF, 4'b0111);
    do_load("lw_dead", 32'h1000, 4'b0111);
    chk("lw_dead_lit", read_data, 32'hDEAD_BEEF);
    do_store("sb_80", 32'h1001, 32'h0000_0080, 4'b0001);
    do_load("lb_80", 32'h1001, 4'b1001);
    chk("lb_80_lit", read_data, 32'hFFFF_FF80);
    do_load("lbu_80", 32'h1001, 4'b0001);
    chk("lbu_80_lit", read_data, 32'h0000_0080);
    do_load("lw_after_sb", 32'h1000, 4'b0111);
    chk("lw_after_sb_lit", read_data, 32'hDEAD_80EF);
    do_store("sh_1234", 32'h1002, 32'h0000_1234, 4'b0011);
    do_load("lh_1234", 32'h1002, 4'b1011);
    chk("lh_1234_lit", read_data, 32'h0000_1234);
    do_load("lw_after_sh", 32'h1000, 4'b0111);
    chk("lw_after_sh_lit", read_data, 32'h1234_80EF);
    do_store("sh_neg", 32'h1000, 32'h0000_8001, 4'b0011);
    do_load("lh_neg", 32'h1000, 4'b1011);
    chk("lh_neg_lit", read_data, 32'hFFFF_8001);
    do_load("lhu_neg", 32'h1000, 4'b0011);
    chk("lhu_neg_lit", read_data, 32'h0000_8001);
  endtask

  task automatic test_led;
    logic [31:0] w;
    do_load("led_pre_word", 32'h1000, 4'b0111);
    w = read_data;
    do_store("sw_led", LEDA, 32'h0000_00FF, 4'b0111);
    chk("led_ff", {24'b0, led}, 32'hFF);
    do_load("lw_led", LEDA, 4'b0111);
    chk("lw_led_lit", read_data, 32'h0000_00FF);
    do_load("led_array_kept", 32'h1000, 4'b0111);
    chk("led_array_kept_lit", read_data, w);
  endtask

  task automatic test_both_and_ignore;
    int e;
    do_store("pre_1004", 32'h1004, 32'h0101_0101, 4'b0111);
    access(1, 1, 32'h1004, 32'hCAFE_F00D, 4'b0111, e);
    chk("both_latency", 32'(e), 32'd3);
    do_load("both_is_store", 32'h1004, 4'b0111);
    chk("both_is_store_lit", read_data, 32'hCAFE_F00D);
    do_store("pre_1008", 32'h1008, 32'h5555_5555, 4'b0111);
    @(negedge clk);
    addr = 32'h1004; memread = 1; sign_mask = 4'b0111;
    @(posedge clk);
    #1;
    memread = 0;
    addr = 32'h1008; write_data = 32'h9999_9999; memwrite = 1;
    @(posedge clk);
    #1;
    memwrite = 0;
    e = 2;
    while (clk_stall && e < 10) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk("ignore_latency", 32'(e), 32'd3);
    chk("ignore_load_val", read_data, 32'hCAFE_F00D);
    last_rd = read_data;
    do_load("ignore_no_write", 32'h1008, 4'b0111);
  endtask

  task automatic test_wrap;
    do_store("wrap_sw", BASE + 32'(DW*4) + 32'h8, 32'h0BAD_F00D, 4'b0111);
    do_load("wrap_lw", 32'h1008, 4'b0111);
    chk("wrap_lw_lit", read_data, 32'h0BAD_F00D);
  endtask

  task automatic test_random;
    logic [31:0] a, wd, held;
    logic [3:0] sm;
    for (int i = 0; i < 16; i++) do_store("rinit", BASE + 32'(i*4), $urandom, 4'b0111);
    for (int i = 0; i < 200; i++) begin
      a = BASE + 32'($urandom_range(0, 63));
      wd = $urandom;
      case ($urandom_range(0, 2))
        0: sm = 4'b0001;
        1: sm = 4'b0011;
        default: sm = 4'b0111;
      endcase
      sm[3] = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        held = read_data;
        do_store("rnd_store", a, wd, sm);
        chk("rnd_rd_hold", read_data, held);
      end else
        do_load("rnd_load", a, sm);
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_buf;
    test_directed;
    test_led;
    test_both_and_ignore;
    test_wrap;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
